// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_t  - frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   clks_per_bit  - bit period in clocks (truncating division)
//   frame_clks    - clocks per complete frame
// Optional parity is controlled by the AXIS_UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS = 8;

`ifdef AXIS_UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Frame = start + data + optional parity + stop bits, all one bit period each.
  function automatic int frame_clks(input int cpb, input int stop_bits);
    return (1 + DATA_BITS + PARITY_BITS + stop_bits) * cpb;
  endfunction

endpackage

// File: rtl/axis_to_uart_tx_if.sv
// axis_to_uart_tx_if: byte-wide AXI-Stream channel.
//   tdata  - byte
//   tvalid - tdata valid
//   tready - sink can accept
// Modports: master (producer), slave (consumer).
interface axis_to_uart_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter.
//   clk, reset - clock, synchronous active-high reset
//   restart    - hold the counter at 0
//   tick       - high in the last cycle of each bit period
//   pre_tick   - high in the second-to-last cycle of each bit period
// The counter wraps on tick, so consecutive bits need no explicit restart.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] cnt;

  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

  always_ff @(posedge clk) begin
    if (reset || restart || tick) cnt <= '0;
    else                          cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/axis_to_uart_tx.sv
// axis_to_uart_tx: AXI-Stream byte sink -> UART TX frame (8N1/8N2, optional parity).
//   clk, reset - clock, synchronous active-high reset
//   axis_in    - slave stream (tdata, tvalid, tready; tready registered)
//   TX         - serial line, idle high (registered)
//   tx_busy    - frame on the line (registered)
// Optional parity bit: define AXIS_UART_TX_PARITY_EN.
module axis_to_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               reset,
  axis_to_uart_tx_if.slave   axis_in,
  output logic               TX,
  output logic               tx_busy
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CPB < 2) begin : g_bad_cpb
    $error("axis_to_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("axis_to_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("axis_to_uart_tx: PARITY_ODD must be 0 or 1");
  end

  uart_state_t state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        tick, pre_tick, restart, accept, last_stop;
`ifdef AXIS_UART_TX_PARITY_EN
  logic        par_bit;
`endif

  // Counter sits at 0 while idle so the start bit gets a full period.
  assign restart   = (state == IDLE);
  assign accept    = axis_in.tvalid && axis_in.tready;
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      TX            <= 1'b1;
      tx_busy       <= 1'b0;
      axis_in.tready <= 1'b0;
      shreg         <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
      par_bit       <= 1'b0;
`endif
    end else if (accept) begin
      // tready is only high in IDLE or the final stop cycle, so this one
      // branch covers both the idle start and the gapless back-to-back start.
      state          <= START;
      TX             <= 1'b0;
      tx_busy        <= 1'b1;
      axis_in.tready <= 1'b0;
      shreg          <= axis_in.tdata;
`ifdef AXIS_UART_TX_PARITY_EN
      par_bit        <= (^axis_in.tdata) ^ PARITY_ODD[0];
`endif
    end else begin
      case (state)
        IDLE: axis_in.tready <= 1'b1;
        START: if (tick) begin
          state   <= DATA;
          TX      <= shreg[0];
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef AXIS_UART_TX_PARITY_EN
            state    <= PARITY;
            TX       <= par_bit;
`else
            state    <= STOP;
            TX       <= 1'b1;
            stop_idx <= 1'b0;
`endif
          end else begin
            shreg   <= shreg >> 1;
            TX      <= shreg[1];
            bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef AXIS_UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state    <= STOP;
          TX       <= 1'b1;
          stop_idx <= 1'b0;
        end
`endif
        STOP: begin
          // Registered tready: raise it one cycle early so it is high
          // exactly in the last cycle of the final stop bit.
          if (last_stop && pre_tick) axis_in.tready <= 1'b1;
          if (tick) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_to_uart_tx.sv
module tb_axis_to_uart_tx;
  localparam int CF = 1000000;
  localparam int BR = 100000;
  localparam int C  = CF / BR;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // index 0: STOP_BITS=1, even parity; index 1: STOP_BITS=2, odd parity
  logic [1:0]      vld;
  logic [1:0][7:0] dat;
  logic [1:0]      tx, busy, rdy;

  int n_asrt = 0;
  int n_fail = 0;
  logic [7:0] bq[$];

  axis_to_uart_tx_if if0 ();
  axis_to_uart_tx_if if1 ();
  assign if0.tvalid = vld[0];
  assign if0.tdata  = dat[0];
  assign if1.tvalid = vld[1];
  assign if1.tdata  = dat[1];
  assign rdy[0] = if0.tready;
  assign rdy[1] = if1.tready;

  axis_to_uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .axis_in(if0), .TX(tx[0]), .tx_busy(busy[0]));
  axis_to_uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
    .clk(clk), .reset(reset), .axis_in(if1), .TX(tx[1]), .tx_busy(busy[1]));

  function automatic int flen(int d);
    return (1 + 8 + P + d + 1) * C;
  endfunction

  // Expected line level at cycle i of a frame carrying byte b.
  function automatic logic exp_tx(int d, logic [7:0] b, int i);
    int bp = i / C;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return b[bp-1];
    if (P == 1 && bp == 9) return (^b) ^ (d == 1);
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(int d);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", 32'(rdy[d]), 1);
  endtask

  // Sends every byte of q back to back, checking each frame cycle by cycle.
  task automatic send_stream(int d, input logic [7:0] q[$], string tag);
    int fl = flen(d);
    int bad_tx, bad_bz, bad_rd, first;
    wait_rdy(d);
    vld[d] = 1'b1;
    dat[d] = q[0];
    for (int k = 0; k < q.size(); k++) begin
      bad_tx = 0; bad_bz = 0; bad_rd = 0; first = -1;
      @(posedge clk);
      @(negedge clk);
      if (k + 1 < q.size()) dat[d] = q[k+1];
      else begin
        vld[d] = 1'b0;
        dat[d] = 8'($urandom);
      end
      for (int i = 0; i < fl; i++) begin
        if (i > 0) @(negedge clk);
        if (tx[d] !== exp_tx(d, q[k], i)) begin
          bad_tx++;
          if (first < 0) first = i;
        end
        if (busy[d] !== 1'b1) bad_bz++;
        if (rdy[d] !== (i == fl - 1)) bad_rd++;
      end
      chk({tag, "_tx_bad_cycles"}, bad_tx, 0);
      if (bad_tx != 0) $display("  byte %02h dut %0d first bad cycle %0d", q[k], d, first);
      chk({tag, "_busy_bad_cycles"}, bad_bz, 0);
      chk({tag, "_rdy_bad_cycles"}, bad_rd, 0);
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, {29'd0, tx[d], busy[d], rdy[d]}, 3'b101);
  endtask

  initial begin
    int bad;
    vld = '0;
    dat = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 2'b11);
    chk("reset_busy", 32'(busy), 2'b00);
    chk("reset_rdy", 32'(rdy), 2'b00);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", 32'(rdy), 2'b11);

    bq = {8'h55};
    send_stream(0, bq, "single55");
    bq = {8'h0F, 8'hF0};
    send_stream(0, bq, "b2b");
    bq = {8'hA5};
    send_stream(0, bq, "a5_even");
    send_stream(1, bq, "a5_odd");
    bq = {8'hFF};
    send_stream(1, bq, "stop2_ff");

    // reset in the middle of data bit 3
    wait_rdy(0);
    vld[0] = 1'b1;
    dat[0] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4 * C + C / 2) @(negedge clk);
    chk("mid_bit3_tx", 32'(tx[0]), 1);
    reset = 1'b1;
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    @(posedge clk);
    #1;
    chk("rst_mid_state", {29'd0, tx[0], busy[0], rdy[0]}, 3'b100);
    @(posedge clk);
    #1;
    chk("rst_no_accept", {29'd0, tx[0], busy[0], rdy[0]}, 3'b100);
    @(negedge clk);
    reset = 1'b0;
    vld[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release", {29'd0, tx[0], busy[0], rdy[0]}, 3'b101);
    bq = {8'h81};
    send_stream(0, bq, "after_rst_81");

    // random streams
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 3);
      bq = {};
      for (int j = 0; j < n; j++) bq.push_back(8'($urandom));
      send_stream(r % 2, bq, "rand");
    end

    // idle: no valid for 1000 cycles
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 2'b11 || busy !== 2'b00 || rdy !== 2'b11) bad++;
    end
    chk("idle_bad_cycles", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
